jesd204_versal_gt_adapter_tx_mc: RTL

JESD204_VERSAL_GT_ADAPTER_TX_MC -- requirements
Module: jesd204_versal_gt_adapter_tx_mc

---
 rtl/jesd204_versal_gt_adapter_tx_mc_if.sv | 71 +++++++
 rtl/jesd204_versal_gt_adapter_tx_mc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204_versal_gt_adapter_tx_mc_if.sv
// ---------------------------------------------------------------------------
// jesd204_versal_gt_adapter_tx_mc_if
//
// Bundles the link-layer side and the GT side of the JESD204 TX adapter.
//
// Signals (NUM_LANES lanes, lane n in the n-th slice of each bus):
//   gt_tx_ready   GT TX datapath reset-done / ready
//   tx_data       64 bits per lane of link-layer data
//   tx_header     2 bits per lane of 64B66B sync header
//   tx_charisk    4 bits per lane of 8B10B K-character flags
//   prbs_en       PRBS7 test-pattern enable (only with JESD204_TX_PRBS_EN)
//   txdata        128 bits per lane towards the GT
//   txheader      6 bits per lane towards the GT
//   txctrl0/1     16 bits per lane, unused GT control (held at zero)
//   txctrl2       8 bits per lane, GT charisk
//   tx_active     high while the adapter passes link data
//
// Modports: master = link layer / stimulus side, slave = adapter side.
// Optional macro: JESD204_TX_PRBS_EN adds prbs_en.
// ---------------------------------------------------------------------------
interface jesd204_versal_gt_adapter_tx_mc_if #(
  parameter int NUM_LANES = 4
);

  logic                      gt_tx_ready;
  logic [NUM_LANES*64-1:0]   tx_data;
  logic [NUM_LANES*2-1:0]    tx_header;
  logic [NUM_LANES*4-1:0]    tx_charisk;
`ifdef JESD204_TX_PRBS_EN
  logic                      prbs_en;
`endif
  logic [NUM_LANES*128-1:0]  txdata;
  logic [NUM_LANES*6-1:0]    txheader;
  logic [NUM_LANES*16-1:0]   txctrl0;
  logic [NUM_LANES*16-1:0]   txctrl1;
  logic [NUM_LANES*8-1:0]    txctrl2;
  logic                      tx_active;

  modport master (
`ifdef JESD204_TX_PRBS_EN
    output prbs_en,
`endif
    output gt_tx_ready,
    output tx_data,
    output tx_header,
    output tx_charisk,
    input  txdata,
    input  txheader,
    input  txctrl0,
    input  txctrl1,
    input  txctrl2,
    input  tx_active
  );

  modport slave (
`ifdef JESD204_TX_PRBS_EN
    input  prbs_en,
`endif
    input  gt_tx_ready,
    input  tx_data,
    input  tx_header,
    input  tx_charisk,
    output txdata,
    output txheader,
    output txctrl0,
    output txctrl1,
    output txctrl2,
    output tx_active
  );

endinterface

// File: rtl/jesd204_versal_gt_adapter_tx_mc.sv
// ---------------------------------------------------------------------------
// jesd204_versal_gt_adapter_tx_mc
//
// Multi-lane JESD204 TX adapter between the link layer and a Versal GT.
// A three-state FSM (IDLE -> SETTLE -> ACTIVE) waits for the GT to report
// ready, lets it settle for SETTLE_CYCLES cycles and then passes link data.
// Outside ACTIVE every lane sends the idle pattern of the selected encoding
// (all-zero data with a data header for 64B66B, K28.5 for 8B10B).
//
// Parameters:
//   LINK_MODE      1 = 8B10B, 2 = 64B66B
//   NUM_LANES      lane count, 1..16
//   SETTLE_CYCLES  settle time after GT ready, 0..65535
//
// Ports:
//   usr_clk  single clock, rising edge
//   reset    synchronous, active-high
//   gt       slave modport of jesd204_versal_gt_adapter_tx_mc_if
//
// Optional macro: JESD204_TX_PRBS_EN adds per-lane PRBS7 generators
// (x^7+x^6+1, 64 bits per cycle) selected by gt.prbs_en while ACTIVE.
// ---------------------------------------------------------------------------
module jesd204_versal_gt_adapter_tx_mc #(
  parameter int LINK_MODE     = 2,
  parameter int NUM_LANES     = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                               usr_clk,
  input  logic                               reset,
  jesd204_versal_gt_adapter_tx_mc_if.slave   gt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Counter value on the last SETTLE cycle; unused when SETTLE_CYCLES is 0
  // because IDLE then skips SETTLE entirely.
  localparam logic [15:0] SETTLE_LAST =
    (SETTLE_CYCLES == 0) ? 16'd0 : 16'(SETTLE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          txActive_q;

  logic [NUM_LANES*128-1:0] txdata_q, txdata_d, idleData;
  logic [NUM_LANES*6-1:0]   txheader_q, txheader_d, idleHeader;
  logic [NUM_LANES*8-1:0]   txctrl2_q, txctrl2_d, idleCtrl2;

  logic laneActive;

  // Depending on LINK_MODE only part of the link-layer buses is used.
  logic unused_inputs;
  assign unused_inputs = ^{gt.tx_data, gt.tx_header, gt.tx_charisk};

  function automatic logic [63:0] bitRev64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) begin
      r[i] = x[63-i];
    end
    return r;
  endfunction

`ifdef JESD204_TX_PRBS_EN
  // Runs the serial PRBS7 LFSR 64 times; word bit 0 is the first bit
  // generated. Returns {next state, word}.
  function automatic logic [70:0] prbs7Step64(input logic [6:0] seed);
    logic [6:0]  s;
    logic [63:0] w;
    logic        fb;
    s = seed;
    w = '0;
    for (int j = 0; j < 64; j++) begin
      fb   = s[6] ^ s[5];
      w[j] = fb;
      s    = {s[5:0], fb};
    end
    return {s, w};
  endfunction

  logic [6:0]  prbsState_q [NUM_LANES];
  logic [6:0]  prbsNext    [NUM_LANES];
  logic [63:0] prbsWord    [NUM_LANES];

  // Each lane owns a generator; identical seeding keeps lanes in lockstep.
  always_comb begin
    for (int n = 0; n < NUM_LANES; n++) begin
      {prbsNext[n], prbsWord[n]} = prbs7Step64(prbsState_q[n]);
    end
  end

  // Reseed on reset and on every entry into ACTIVE so the pattern always
  // starts from the same point after a link (re)start.
  always_ff @(posedge usr_clk) begin
    for (int n = 0; n < NUM_LANES; n++) begin
      if (reset || (state_d == ACTIVE && state_q != ACTIVE)) begin
        prbsState_q[n] <= 7'h7F;
      end else if (state_q == ACTIVE && gt.prbs_en) begin
        prbsState_q[n] <= prbsNext[n];
      end
    end
  end
`endif

  // FSM next state. Loss of GT ready wins over every other transition and
  // clears the settle counter (cnt_d defaults to zero).
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (gt.gt_tx_ready) begin
          state_d = (SETTLE_CYCLES == 0) ? ACTIVE : SETTLE;
        end
      end
      SETTLE: begin
        if (!gt.gt_tx_ready) begin
          state_d = IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ACTIVE: begin
        if (!gt.gt_tx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register; tx_active is registered from the next state so it
  // is high on exactly the cycles the FSM sits in ACTIVE.
  always_ff @(posedge usr_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      txActive_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      txActive_q <= (state_d == ACTIVE);
    end
  end

  assign laneActive = (state_q == ACTIVE);

  // Idle pattern per lane for the selected encoding.
  always_comb begin
    idleData   = '0;
    idleHeader = '0;
    idleCtrl2  = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      if (LINK_MODE == 1) begin
        idleData[128*n +: 32] = 32'hBCBCBCBC;
        idleCtrl2[8*n +: 8]   = 8'h0F;
      end else begin
        idleHeader[6*n +: 6]  = 6'b000010;
      end
    end
  end

  // Lane mapping, gated by the current FSM state. The GT expects the
  // 64B66B payload bit-reversed and the two header bits swapped.
  always_comb begin
    txdata_d   = idleData;
    txheader_d = idleHeader;
    txctrl2_d  = idleCtrl2;
    if (laneActive) begin
      txdata_d   = '0;
      txheader_d = '0;
      txctrl2_d  = '0;
      for (int n = 0; n < NUM_LANES; n++) begin
        if (LINK_MODE == 1) begin
          txdata_d[128*n +: 32] = gt.tx_data[64*n +: 32];
          txheader_d[6*n +: 2]  = gt.tx_header[2*n +: 2];
          txctrl2_d[8*n +: 4]   = gt.tx_charisk[4*n +: 4];
        end else begin
          txdata_d[128*n +: 64] = bitRev64(gt.tx_data[64*n +: 64]);
          txheader_d[6*n +: 2]  = {gt.tx_header[2*n], gt.tx_header[2*n+1]};
        end
`ifdef JESD204_TX_PRBS_EN
        if (gt.prbs_en) begin
          if (LINK_MODE == 1) begin
            txdata_d[128*n +: 32] = prbsWord[n][31:0];
            txctrl2_d[8*n +: 8]   = 8'h00;
          end else begin
            txdata_d[128*n +: 64] = bitRev64(prbsWord[n]);
            txheader_d[6*n +: 6]  = 6'b000010;
          end
        end
`endif
      end
    end
  end

  // GT output register: one usr_clk of latency, idle pattern under reset.
  always_ff @(posedge usr_clk) begin
    if (reset) begin
      txdata_q   <= idleData;
      txheader_q <= idleHeader;
      txctrl2_q  <= idleCtrl2;
    end else begin
      txdata_q   <= txdata_d;
      txheader_q <= txheader_d;
      txctrl2_q  <= txctrl2_d;
    end
  end

  assign gt.txdata    = txdata_q;
  assign gt.txheader  = txheader_q;
  assign gt.txctrl2   = txctrl2_q;
  assign gt.txctrl0   = '0;
  assign gt.txctrl1   = '0;
  assign gt.tx_active = txActive_q;

endmodule
